// File: rtl/gy25_pkg.sv
// rtl/gy25_pkg.sv - shared state encodings and default framing bytes for the GY25 parser
package gy25_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } gy25_state_e;

  localparam logic [7:0] GY25_HDR_BYTE_DEF  = 8'hAA;
  localparam logic [7:0] GY25_TAIL_BYTE_DEF = 8'h55;
  localparam int         GY25_PAYLOAD_BYTES = 6;

endpackage

// File: rtl/gy25_timeout.sv
// rtl/gy25_timeout.sv - inter-byte watchdog: counts enabled cycles, clears on demand, flags the last allowed cycle
module gy25_timeout #(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/gy25_frame_parser.sv
// rtl/gy25_frame_parser.sv - decodes AA + 6 payload bytes + 55 frames into yaw/pitch/roll
// Angles are only committed from shadow registers on a good tail, so they never update partially.
module gy25_frame_parser
  import gy25_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] HDR_BYTE    = GY25_HDR_BYTE_DEF,
  parameter logic [7:0] TAIL_BYTE   = GY25_TAIL_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [7:0]  data_byte,
  output logic [15:0] yaw,
  output logic [15:0] pitch,
  output logic [15:0] roll,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  gy25_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q [GY25_PAYLOAD_BYTES];
  logic [7:0]  sh_d [GY25_PAYLOAD_BYTES];
  logic [15:0] yaw_q, yaw_d, pitch_q, pitch_d, roll_q, roll_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        rx_d1_q, rx_d1_d;
  logic        sample;
  logic        in_frame;
  logic        expire;

  // data_byte settles one cycle after rx_done, so sample on the delayed strobe
  assign rx_d1_d  = rx_done;
  assign sample   = rx_d1_q;
  assign in_frame = (state_q != ST_HUNT);

  gy25_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (in_frame),
    .clear  (sample || !in_frame),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sh_d          = sh_q;
    yaw_d         = yaw_q;
    pitch_d       = pitch_q;
    roll_d        = roll_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      ST_HUNT: begin
        if (sample && (data_byte == HDR_BYTE)) begin
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample) begin
          for (int i = 0; i < GY25_PAYLOAD_BYTES; i++) begin
            if (idx_q == 3'(i)) begin
              sh_d[i] = data_byte;
            end
          end
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(GY25_PAYLOAD_BYTES - 1)) begin
            state_d = ST_TAIL;
          end
        end else if (expire) begin
          frame_err_d = 1'b1;
          state_d     = ST_HUNT;
        end
      end
      ST_TAIL: begin
        if (sample) begin
          if (data_byte == TAIL_BYTE) begin
            yaw_d         = {sh_q[0], sh_q[1]};
            pitch_d       = {sh_q[2], sh_q[3]};
            roll_d        = {sh_q[4], sh_q[5]};
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_HUNT;
        end else if (expire) begin
          frame_err_d = 1'b1;
          state_d     = ST_HUNT;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      idx_q         <= 3'd0;
      rx_d1_q       <= 1'b0;
      yaw_q         <= 16'd0;
      pitch_q       <= 16'd0;
      roll_q        <= 16'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= 8'd0;
      for (int i = 0; i < GY25_PAYLOAD_BYTES; i++) begin
        sh_q[i] <= 8'd0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rx_d1_q       <= rx_d1_d;
      yaw_q         <= yaw_d;
      pitch_q       <= pitch_d;
      roll_q        <= roll_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_cnt_q     <= err_cnt_d;
      for (int i = 0; i < GY25_PAYLOAD_BYTES; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

  assign yaw         = yaw_q;
  assign pitch       = pitch_q;
  assign roll        = roll_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_gy25_frame_parser.sv
// tb/tb_gy25_frame_parser.sv - directed self-checking bench for gy25_frame_parser
module tb_gy25_frame_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  data_byte = 8'h00;
  logic [15:0] yaw, pitch, roll;
  logic        frame_valid, frame_err;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  int fv_seen   = 0;
  int fe_seen   = 0;
  int both_seen = 0;

  gy25_frame_parser #(
    .TIMEOUT_CYC (100),
    .HDR_BYTE    (8'hAA),
    .TAIL_BYTE   (8'h55)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_done     (rx_done),
    .data_byte   (data_byte),
    .yaw         (yaw),
    .pitch       (pitch),
    .roll        (roll),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_seen = fv_seen + 1;
    if (frame_err) fe_seen = fe_seen + 1;
    if (frame_valid && frame_err) both_seen = both_seen + 1;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
  endtask

  // rx_done pulse, then the byte appears on the following cycle
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    @(negedge clk);
    rx_done   = 1'b0;
    data_byte = b;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 7; i >= 0; i--) begin
      send_byte(f[i*8 +: 8]);
      idle(1);
    end
  endtask

  task automatic check_angles(input string name, input logic [15:0] ey, input logic [15:0] ep,
                              input logic [15:0] er);
    total++;
    if ({yaw, pitch, roll} !== {ey, ep, er}) begin
      bad++;
      $display("FAIL %s: got yaw=%h pitch=%h roll=%h want yaw=%h pitch=%h roll=%h",
               name, yaw, pitch, roll, ey, ep, er);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({yaw, pitch, roll, frame_valid, frame_err, err_cnt} !== 58'd0) begin
      bad++;
      $display("FAIL reset_outputs: got yaw=%h pitch=%h roll=%h fv=%b fe=%b err_cnt=%0d want all 0",
               yaw, pitch, roll, frame_valid, frame_err, err_cnt);
    end
  endtask

  task automatic test_basic_frame();
    logic [63:0] f;
    int fv0, fe0;
    f = 64'hAA1234FF9C006455;
    fv0 = fv_seen; fe0 = fe_seen;
    for (int i = 7; i >= 1; i--) begin
      send_byte(f[i*8 +: 8]);
      idle(1);
    end
    send_byte(8'h55);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_fv_early: got %b want 0", frame_valid);
    end
    @(negedge clk);
    total++;
    if (frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_fv_latency: got %b want 1", frame_valid);
    end
    idle(3);
    check_angles("basic_angles", 16'h1234, 16'hFF9C, 16'h0064);
    total++;
    if ((fv_seen - fv0) != 1 || (fe_seen - fe0) != 0) begin
      bad++;
      $display("FAIL basic_pulses: got fv=%0d fe=%0d want fv=1 fe=0", fv_seen - fv0, fe_seen - fe0);
    end
  endtask

  task automatic test_leading_junk();
    int fv0, fe0;
    do_reset();
    fv0 = fv_seen; fe0 = fe_seen;
    send_byte(8'h00); idle(1);
    send_byte(8'h55); idle(1);
    send_frame(64'hAA1234FF9C006455);
    idle(3);
    check_angles("junk_angles", 16'h1234, 16'hFF9C, 16'h0064);
    total++;
    if ((fv_seen - fv0) != 1 || (fe_seen - fe0) != 0) begin
      bad++;
      $display("FAIL junk_pulses: got fv=%0d fe=%0d want fv=1 fe=0", fv_seen - fv0, fe_seen - fe0);
    end
  endtask

  task automatic test_bad_tail();
    int fv0, fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    send_frame(64'hAA010203040506AB);
    idle(3);
    check_angles("badtail_hold", 16'h1234, 16'hFF9C, 16'h0064);
    total++;
    if ((fv_seen - fv0) != 0 || (fe_seen - fe0) != 1 || err_cnt !== 8'd1) begin
      bad++;
      $display("FAIL badtail_err: got fv=%0d fe=%0d err_cnt=%0d want fv=0 fe=1 err_cnt=1",
               fv_seen - fv0, fe_seen - fe0, err_cnt);
    end
  endtask

  task automatic test_hdr_in_data();
    send_frame(64'hAAAA01AA02030455);
    idle(3);
    check_angles("hdr_in_data", 16'hAA01, 16'hAA02, 16'h0304);
  endtask

  task automatic test_slow_frame();
    logic [63:0] f;
    int fe0;
    f = 64'hAA0A0B0C0D0E0F55;
    fe0 = fe_seen;
    for (int i = 7; i >= 0; i--) begin
      send_byte(f[i*8 +: 8]);
      idle(80);
    end
    check_angles("slow_angles", 16'h0A0B, 16'h0C0D, 16'h0E0F);
    total++;
    if ((fe_seen - fe0) != 0) begin
      bad++;
      $display("FAIL slow_no_timeout: got fe=%0d want 0", fe_seen - fe0);
    end
  endtask

  task automatic test_timeout();
    int fe0, ec0, waited;
    fe0 = fe_seen; ec0 = int'(err_cnt);
    send_byte(8'hAA); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h02); idle(1);
    idle(90);
    total++;
    if ((fe_seen - fe0) != 0) begin
      bad++;
      $display("FAIL timeout_early: got fe=%0d want 0 after 90 idle cycles", fe_seen - fe0);
    end
    waited = 0;
    while ((fe_seen - fe0) == 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if ((fe_seen - fe0) != 1 || int'(err_cnt) != ec0 + 1) begin
      bad++;
      $display("FAIL timeout_fire: got fe=%0d err_cnt=%0d want fe=1 err_cnt=%0d",
               fe_seen - fe0, err_cnt, ec0 + 1);
    end
    send_frame(64'hAA11223344556655);
    idle(3);
    check_angles("timeout_recover", 16'h1122, 16'h3344, 16'h5566);
  endtask

  task automatic test_reset_mid_frame();
    int fv0, fe0;
    send_byte(8'hAA); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h03); idle(1);
    fv0 = fv_seen; fe0 = fe_seen;
    do_reset();
    total++;
    if ({yaw, pitch, roll, err_cnt} !== 56'd0 || (fv_seen - fv0) != 0 || (fe_seen - fe0) != 0) begin
      bad++;
      $display("FAIL midreset_clear: got yaw=%h pitch=%h roll=%h err_cnt=%0d fv=%0d fe=%0d want all 0",
               yaw, pitch, roll, err_cnt, fv_seen - fv0, fe_seen - fe0);
    end
    send_frame(64'hAA7FFF8000010255);
    idle(3);
    check_angles("midreset_next", 16'h7FFF, 16'h8000, 16'h0102);
  endtask

  task automatic test_saturate();
    int fe0;
    do_reset();
    fe0 = fe_seen;
    for (int n = 0; n < 300; n++) begin
      send_frame(64'hAA010203040506AB);
    end
    idle(3);
    total++;
    if (err_cnt !== 8'd255 || (fe_seen - fe0) != 300) begin
      bad++;
      $display("FAIL saturate: got err_cnt=%0d fe=%0d want err_cnt=255 fe=300", err_cnt, fe_seen - fe0);
    end
    check_angles("saturate_hold", 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_leading_junk();
    test_bad_tail();
    test_hdr_in_data();
    test_slow_frame();
    test_timeout();
    test_reset_mid_frame();
    test_saturate();
    total++;
    if (both_seen != 0) begin
      bad++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", both_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gy25_frame_parser.md
GY25_FRAME_PARSER -- requirements
Module: gy25_frame_parser

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: clk cycles allowed between bytes inside a frame.
REQ-002 Parameter HDR_BYTE, default 8'hAA: frame header value.
REQ-003 Parameter TAIL_BYTE, default 8'h55: frame tail value.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 rx_done  input  1  one-cycle pulse from the GY25 UART receiver.
REQ-007 data_byte  input  8  received byte; valid from the cycle after rx_done, held until the next byte.
REQ-008 yaw  output  16  signed angle, byte 1 high, byte 2 low.
REQ-009 pitch  output  16  signed angle, byte 3 high, byte 4 low.
REQ-010 roll  output  16  signed angle, byte 5 high, byte 6 low.
REQ-011 frame_valid  output  1  one-cycle pulse; yaw, pitch and roll were just updated.
REQ-012 frame_err  output  1  one-cycle pulse on a tail mismatch or a timeout.
REQ-013 err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-014 The block SHALL register rx_done into rx_d1 and sample data_byte only in the cycle rx_d1=1.
REQ-015 The FSM SHALL have three states: HUNT, DATA, TAIL.
REQ-016 HUNT: a sampled byte equal to HDR_BYTE SHALL set idx=0, clear the timeout counter and go to DATA; any other byte SHALL be ignored.
REQ-017 DATA: each sampled byte SHALL be written to shadow register sh[idx] and idx SHALL increment.
REQ-018 DATA: the sixth byte (idx=5) SHALL move the FSM to TAIL.
REQ-019 Bytes equal to HDR_BYTE inside DATA SHALL be treated as data; there is no resynchronisation mid-frame.
REQ-020 TAIL: a sampled byte equal to TAIL_BYTE SHALL copy the shadow registers to yaw/pitch/roll and pulse frame_valid together, one cycle after the sampling cycle, then go to HUNT.
REQ-021 TAIL: any other byte SHALL pulse frame_err, leave the outputs unchanged and go to HUNT; that byte is not re-examined as a header.
REQ-022 In DATA or TAIL, the timeout counter SHALL increment every cycle and clear on each sampled byte.
REQ-023 When the timeout counter reaches TIMEOUT_CYC-1 with no byte, the block SHALL pulse frame_err and go to HUNT.
REQ-024 If a byte is sampled in the same cycle the timeout would fire, the byte SHALL take priority and no timeout SHALL occur.
REQ-025 err_cnt SHALL increment on each frame_err pulse and saturate at 255.
REQ-026 yaw, pitch and roll SHALL change only together with frame_valid; they SHALL never be partially updated.
REQ-027 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-028 Width rules: idx is 3 bits; the timeout counter is $clog2(TIMEOUT_CYC) bits; there is no arithmetic on the angle data.

Reset
REQ-029 rst SHALL return the FSM to HUNT and clear idx, rx_d1, the timeout counter and the shadow registers.
REQ-030 rst SHALL clear yaw, pitch, roll, frame_valid, frame_err and err_cnt to 0.
REQ-031 rst asserted mid-frame SHALL discard the partial frame without pulsing frame_err.

Structure
REQ-032 State encodings SHALL be defined in shared package gy25_pkg; HDR_BYTE and TAIL_BYTE defaults SHALL also be defined there.
REQ-033 The timeout counter MAY be a sub-module gy25_timeout (enable, clear, expire); all other logic is flat.

Verification
REQ-034 Frame AA 12 34 FF 9C 00 64 55 -> one frame_valid; yaw=16'h1234, pitch=16'hFF9C (-100), roll=16'h0064.
REQ-035 Bytes 00 55 then the REQ-034 frame -> leading bytes ignored; exactly one frame_valid with the REQ-034 values.
REQ-036 Frame AA 01 02 03 04 05 06 AB -> frame_err pulse; err_cnt=1; outputs keep the previous frame's values.
REQ-037 AA 01 02, then idle for TIMEOUT_CYC cycles (TIMEOUT_CYC=100) -> frame_err pulse; FSM in HUNT; the following valid frame is accepted.
REQ-038 rst asserted after AA 01 02 03 -> all outputs 0; err_cnt=0; no pulses; the next full frame is decoded correctly.
REQ-039 300 consecutive bad-tail frames -> err_cnt stops at 255.
